dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one data memory port between N_CORES matrix-multiply cores. Each core's
//  read_MD/write_MD strobes become requests. One request is granted at a time, in
//  round-robin order. The memory access is sequenced and the requester gets a
//  one-cycle ack, with read data when the request was a read.
//  Sits between the cores' ar_out/dmem_out/dmem_in ports and the shared data RAM.
//  Uses the same clk as the cores.
// PARAMETERS
//  N_CORES  4   number of requesting cores (2..8)
//  AW       16  address width (core ar_out width)
//  DW       16  data width (dmem_in/dmem_out width)
//  MEM_LAT  1   RAM read latency in cycles, mem_re to mem_rdata valid (1..4)
// PORTS
//  clk        in   1          system clock; all state updates on the rising edge
//  RESET      in   1          asynchronous, active-low reset
//  core_rd    in   N_CORES    per-core read request (core read_MD)
//  core_wr    in   N_CORES    per-core write request (core write_MD)
//  core_addr  in   N_CORES*AW packed core addresses; core k in [k*AW +: AW]
//  core_wdata in   N_CORES*DW packed core write data; core k in [k*DW +: DW]
//  core_ack   out  N_CORES    one-hot, one-cycle completion pulse to the granted core
//  core_rdata out  DW         read data, broadcast to all cores; valid while core_ack is high
//  mem_addr   out  AW         RAM address
//  mem_wdata  out  DW         RAM write data
//  mem_we     out  1          RAM write strobe (one cycle)
//  mem_re     out  1          RAM read strobe (one cycle)
//  mem_rdata  in   DW         RAM read data, valid MEM_LAT cycles after mem_re
//  busy       out  1          high in every state except IDLE
//  err        out  1          sticky: some core raised rd and wr together
// BEHAVIOUR
//  Reset (RESET=0, asynchronous):
//   - State goes to IDLE.
//   - All outputs go to 0: core_ack, core_rdata, mem_*, busy, err.
//   - Round-robin pointer last goes to N_CORES-1, so core 0 wins the first arbitration.
//   - The latency counter clears.
//   - A transfer in flight is abandoned and no ack is issued. The RAM may already
//     have been written.
//  Request: req[k] = core_rd[k] | core_wr[k]. Requests are sampled only in IDLE.
//  Requester rule: hold rd/wr and addr/wdata stable until core_ack[k] is seen;
//   deassert them in the cycle after the ack.
//  FSM:
//   - IDLE: if any req, grant g = first requesting index after last (cyclic).
//     Latch addr[g], wdata[g], op; op = write if core_wr[g] is high. -> ACCESS.
//     With no request, stay in IDLE.
//   - ACCESS (1 cycle): drive mem_addr from the latched address. Write: mem_we=1 and
//     mem_wdata from the latched data, then -> RESP. Read: mem_re=1, then -> WAIT.
//   - WAIT (MEM_LAT cycles): count down; on the last WAIT cycle capture mem_rdata into
//     the rdata register. -> RESP.
//   - RESP (1 cycle): core_ack[g]=1 and core_rdata = captured data (reads only; on
//     writes core_rdata holds its previous value). Set last = g. -> IDLE.
//  Latency, request first seen in IDLE at cycle 0:
//   - write: mem_we in cycle 1, ack in cycle 2.
//   - read: mem_re in cycle 1, ack in cycle 2+MEM_LAT.
//  Throughput: one transfer per (3 + MEM_LAT*is_read) cycles, including the IDLE cycle.
//  Boundary conditions:
//   - rd and wr together on one core: treated as a write, err set to 1. err stays set
//     until reset.
//   - A request withdrawn after grant: the transfer still completes and ack is still
//     pulsed.
//   - Requests from other cores during a transfer wait; they are not lost or queued
//     beyond their held level.
//   - Pointer wrap: after g = N_CORES-1 the search starts at core 0.
//   - Single requester: re-granted back to back, one IDLE cycle between acks.
//   - No two bits of core_ack are ever high in the same cycle.
//   - mem_we and mem_re are never high in the same cycle.
// TESTING
//  1. Reset, then core0 writes 0x00A5 to addr 0x0010 -> mem_we=1 with addr 0x0010 and
//     data 0x00A5 in cycle 1; core_ack=4'b0001 in cycle 2; busy low in cycle 3.
//  2. Preload RAM[0x0020]=0x1234; core2 reads with MEM_LAT=1 -> mem_re in cycle 1;
//     core_ack=4'b0100 with core_rdata=0x1234 in cycle 3.
//  3. All four cores request writes at once from reset -> ack order 0,1,2,3 in one-hot
//     form, 3 cycles apart; RAM holds each core's data.
//  4. Core3 served, then cores 1 and 3 request -> core1 is granted first (wrap from
//     last=3 starts at core 0).
//  5. Core1 raises rd and wr with data 0xBEEF -> write performed, err=1 and it stays 1
//     across later clean transfers until RESET=0.
//  6. Pull RESET low during WAIT of a read -> no ack; all outputs 0 asynchronously;
//     after release, core0 has first priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data-memory port between N_CORES cores.
// Each granted request runs IDLE -> ACCESS -> (WAIT x MEM_LAT for reads) -> RESP,
// and the requester receives a one-cycle ack, with the read data on reads.
module dmem_arbiter #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [N_CORES-1:0]    core_rd,
    input  logic [N_CORES-1:0]    core_wr,
    input  logic [N_CORES*AW-1:0] core_addr,
    input  logic [N_CORES*DW-1:0] core_wdata,
    output logic [N_CORES-1:0]    core_ack,
    output logic [DW-1:0]         core_rdata,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IW = $clog2(N_CORES);
    localparam int unsigned CW = 3;  // holds MEM_LAT-1 for MEM_LAT up to 4

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               is_wr_q, is_wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [N_CORES-1:0] req;
    logic [IW-1:0]      cand;
    logic [IW-1:0]      gsel;
    logic               found;

    assign req = core_rd | core_wr;

    // Cyclic search for the first requester after the last granted core
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_CORES; i++) begin
            cand = IW'((32'(last_q) + i) % N_CORES);
            if (!found && req[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    // Next-state logic and decoded memory/ack strobes
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        is_wr_d  = is_wr_q;
        cnt_d    = cnt_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        core_ack = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = gsel;
                    addr_d  = core_addr[gsel*AW +: AW];
                    wdata_d = core_wdata[gsel*DW +: DW];
                    // rd and wr together resolve to a write
                    is_wr_d = core_wr[gsel];
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (is_wr_q) begin
                    mem_we  = 1'b1;
                    state_d = StResp;
                end else begin
                    mem_re  = 1'b1;
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                core_ack[grant_q] = 1'b1;
                last_d            = grant_q;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky protocol error: any core strobing rd and wr in the same cycle
    assign err_d = err_q | (|(core_rd & core_wr));

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IW'(N_CORES - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_rdata = rdata_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a RAM model with one-cycle read latency,
// a scoreboard of expected acks checked every cycle, and one task per scenario.
module tb_dmem_arbiter;

    localparam int N       = 4;
    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int MEM_LAT = 1;

    logic              clk;
    logic              RESET;
    logic [N-1:0]      core_rd;
    logic [N-1:0]      core_wr;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_ack;
    logic [DW-1:0]     core_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic              err;

    typedef struct {
        int          core;
        bit          is_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [N-1:0] last_ack;

    logic [15:0] ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    dmem_arbiter #(
        .N_CORES (N),
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data registered one cycle after mem_re
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic set_req(input int k, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] d);
        core_rd[k]            = rd;
        core_wr[k]            = wr;
        core_addr[k*AW +: AW]  = a;
        core_wdata[k*DW +: DW] = d;
    endtask

    task automatic expect_ack(input int k, input bit rd, input logic [15:0] d);
        exp_t e;
        e.core  = k;
        e.is_rd = rd;
        e.rdata = d;
        sb.push_back(e);
    endtask

    // Advance one cycle: requesters drop strobes after their ack, then sample at negedge
    task automatic step();
        exp_t       e;
        logic [3:0] oh;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (last_ack[k]) begin
                core_rd[k] = 1'b0;
                core_wr[k] = 1'b0;
            end
        end
        @(negedge clk);
        last_ack = core_ack;
        if (RESET) begin
            vectors++;
            if (!$onehot0(core_ack) || (mem_we && mem_re)) begin
                miscompares++;
                $display("FAIL invariant: core_ack=%b mem_we=%b mem_re=%b, required onehot0 ack, not both strobes",
                         core_ack, mem_we, mem_re);
            end
            if (core_ack != '0) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ack: core_ack=%b, required none", core_ack);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.core;
                    if (core_ack !== oh || (e.is_rd && core_rdata !== e.rdata)) begin
                        miscompares++;
                        $display("FAIL sb_ack: core_ack=%b rdata=%h, required %b rdata=%h",
                                 core_ack, core_rdata, oh, e.rdata);
                    end
                end
            end
        end
    endtask

    // Steps until an ack appears; n is cycles taken, -1 if none within budget
    task automatic wait_ack(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (core_ack != '0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        @(negedge clk);
        last_ack = core_ack;
    endtask

    task automatic pulse_reset();
        RESET    = 1'b0;
        core_rd  = '0;
        core_wr  = '0;
        sb.delete();
        last_ack = '0;
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({core_ack, mem_we, mem_re, busy, err} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: ack=%b we=%b re=%b busy=%b err=%b, required all 0",
                     core_ack, mem_we, mem_re, busy, err);
        end
        vectors++;
        if (core_rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required 0",
                     core_rdata, mem_addr, mem_wdata);
        end
        RESET = 1'b1;
        step();
    endtask

    task automatic test_write();
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'h00A5);
        expect_ack(0, 1'b0, 16'h0);
        step();
        vectors++;
        if (!(mem_we === 1'b1 && mem_re === 1'b0 && mem_addr === 16'h0010 && mem_wdata === 16'h00A5)) begin
            miscompares++;
            $display("FAIL write_access: we=%b re=%b addr=%h data=%h, required 1 0 0010 00a5",
                     mem_we, mem_re, mem_addr, mem_wdata);
        end
        step();
        vectors++;
        if (core_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL write_ack: core_ack=%b, required 0001", core_ack);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_idle: busy=%b, required 0", busy);
        end
        vectors++;
        if (ram[16'h0010] !== 16'h00A5) begin
            miscompares++;
            $display("FAIL write_ram: ram=%h, required 00a5", ram[16'h0010]);
        end
    endtask

    task automatic test_read();
        preload(16'h0020, 16'h1234);
        set_req(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_ack(2, 1'b1, 16'h1234);
        step();
        vectors++;
        if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === 16'h0020)) begin
            miscompares++;
            $display("FAIL read_access: re=%b we=%b addr=%h, required 1 0 0020", mem_re, mem_we, mem_addr);
        end
        step();
        vectors++;
        if (core_ack !== 4'b0000 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL read_wait: ack=%b busy=%b, required 0000 1", core_ack, busy);
        end
        step();
        vectors++;
        if (core_ack !== 4'b0100 || core_rdata !== 16'h1234) begin
            miscompares++;
            $display("FAIL read_ack: ack=%b rdata=%h, required 0100 1234", core_ack, core_rdata);
        end
        step();
    endtask

    task automatic test_all_four();
        int         n;
        logic [3:0] oh;
        pulse_reset();
        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b0, 1'b1, 16'h0100 + 16'(k), 16'hC000 + 16'(k));
            expect_ack(k, 1'b0, 16'h0);
        end
        for (int k = 0; k < N; k++) begin
            wait_ack(n);
            oh = 4'b0001 << k;
            vectors++;
            if (n != ((k == 0) ? 2 : 3) || core_ack !== oh) begin
                miscompares++;
                $display("FAIL all4_order: cycles=%0d ack=%b, required %0d %b",
                         n, core_ack, (k == 0) ? 2 : 3, oh);
            end
        end
        step();
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (ram[16'h0100 + 16'(k)] !== 16'hC000 + 16'(k)) begin
                miscompares++;
                $display("FAIL all4_ram: core %0d ram=%h, required %h",
                         k, ram[16'h0100 + 16'(k)], 16'hC000 + 16'(k));
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        set_req(1, 1'b0, 1'b1, 16'h0200, 16'h1111);
        set_req(3, 1'b0, 1'b1, 16'h0203, 16'h3333);
        expect_ack(1, 1'b0, 16'h0);
        expect_ack(3, 1'b0, 16'h0);
        wait_ack(n);
        vectors++;
        if (n != 2 || core_ack !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_first: cycles=%0d ack=%b, required 2 0010", n, core_ack);
        end
        wait_ack(n);
        vectors++;
        if (n != 3 || core_ack !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_second: cycles=%0d ack=%b, required 3 1000", n, core_ack);
        end
        step();
    endtask

    task automatic test_err();
        int n;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        set_req(1, 1'b1, 1'b1, 16'h0030, 16'hBEEF);
        expect_ack(1, 1'b0, 16'h0);
        step();
        vectors++;
        if (!(mem_we === 1'b1 && mem_re === 1'b0 && mem_addr === 16'h0030 &&
              mem_wdata === 16'hBEEF && err === 1'b1)) begin
            miscompares++;
            $display("FAIL err_write: we=%b re=%b addr=%h data=%h err=%b, required 1 0 0030 beef 1",
                     mem_we, mem_re, mem_addr, mem_wdata, err);
        end
        wait_ack(n);
        vectors++;
        if (n != 1 || core_ack !== 4'b0010) begin
            miscompares++;
            $display("FAIL err_ack: cycles=%0d ack=%b, required 1 0010", n, core_ack);
        end
        step();
        set_req(2, 1'b1, 1'b0, 16'h0030, 16'h0);
        expect_ack(2, 1'b1, 16'hBEEF);
        wait_ack(n);
        vectors++;
        if (n != 3 || core_rdata !== 16'hBEEF || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: cycles=%0d rdata=%h err=%b, required 3 beef 1", n, core_rdata, err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        set_req(2, 1'b0, 1'b1, 16'h0040, 16'h0001);
        expect_ack(2, 1'b0, 16'h0);
        wait_ack(n);
        vectors++;
        if (n != 2 || core_ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL b2b_first: cycles=%0d ack=%b, required 2 0100", n, core_ack);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy);
        end
        set_req(2, 1'b0, 1'b1, 16'h0041, 16'h0002);
        expect_ack(2, 1'b0, 16'h0);
        wait_ack(n);
        vectors++;
        if (n != 2 || core_ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL b2b_second: cycles=%0d ack=%b, required 2 0100", n, core_ack);
        end
        step();
        vectors++;
        if (ram[16'h0041] !== 16'h0002) begin
            miscompares++;
            $display("FAIL b2b_ram: ram=%h, required 0002", ram[16'h0041]);
        end
    endtask

    task automatic test_withdraw();
        int n;
        set_req(3, 1'b0, 1'b1, 16'h0050, 16'h5A5A);
        expect_ack(3, 1'b0, 16'h0);
        step();
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0050) begin
            miscompares++;
            $display("FAIL withdraw_access: we=%b addr=%h, required 1 0050", mem_we, mem_addr);
        end
        core_wr[3] = 1'b0;
        wait_ack(n);
        vectors++;
        if (n != 1 || core_ack !== 4'b1000) begin
            miscompares++;
            $display("FAIL withdraw_ack: cycles=%0d ack=%b, required 1 1000", n, core_ack);
        end
        step();
        vectors++;
        if (ram[16'h0050] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL withdraw_ram: ram=%h, required 5a5a", ram[16'h0050]);
        end
    endtask

    task automatic test_reset_in_wait();
        int   n;
        logic seen;
        set_req(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_ack(1, 1'b1, 16'h1234);
        step();
        vectors++;
        if (mem_re !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_access: re=%b, required 1", mem_re);
        end
        step();
        vectors++;
        if (busy !== 1'b1 || core_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstwait_wait: busy=%b ack=%b, required 1 0000", busy, core_ack);
        end
        RESET = 1'b0;
        #1;
        vectors++;
        if ({core_ack, mem_we, mem_re, busy, err} !== 8'h00 || core_rdata !== 16'h0 ||
            mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rstwait_async: ack=%b we=%b re=%b busy=%b err=%b rdata=%h addr=%h wdata=%h, required all 0",
                     core_ack, mem_we, mem_re, busy, err, core_rdata, mem_addr, mem_wdata);
        end
        sb.delete();
        core_rd  = '0;
        core_wr  = '0;
        last_ack = '0;
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (core_ack != '0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_noack: ack seen=%b, required 0", seen);
        end
        set_req(3, 1'b0, 1'b1, 16'h0060, 16'h6666);
        set_req(0, 1'b0, 1'b1, 16'h0061, 16'h7777);
        expect_ack(0, 1'b0, 16'h0);
        expect_ack(3, 1'b0, 16'h0);
        wait_ack(n);
        vectors++;
        if (n != 2 || core_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstwait_prio: cycles=%0d ack=%b, required 2 0001", n, core_ack);
        end
        wait_ack(n);
        vectors++;
        if (n != 3 || core_ack !== 4'b1000) begin
            miscompares++;
            $display("FAIL rstwait_next: cycles=%0d ack=%b, required 3 1000", n, core_ack);
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_ack    = '0;
        core_rd     = '0;
        core_wr     = '0;
        core_addr   = '0;
        core_wdata  = '0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        RESET       = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_all_four();
        test_wrap();
        test_err();
        test_back_to_back();
        test_withdraw();
        test_reset_in_wait();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d acks outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
